// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   REG_W    : register address width
//   DATA_W   : register data width
//   wb_req_t : one pending register write (destination + data)
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Multdiv result handshake into the writeback arbiter.
//   md_valid : result valid (held with stable rd/data until accepted)
//   md_rd    : result destination register
//   md_data  : result value
//   md_ready : arbiter queue can accept a result
// master = multdiv unit, slave = arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned REG_W  = regfile_wb_arbiter_pkg::REG_W,
  parameter int unsigned DATA_W = regfile_wb_arbiter_pkg::DATA_W
);
  logic              md_valid;
  logic [REG_W-1:0]  md_rd;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;

  modport master (output md_valid, output md_rd, output md_data, input md_ready);
  modport slave  (input md_valid, input md_rd, input md_data, output md_ready);
endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// In-order circular buffer of pending multdiv writes.
// Each entry carries rd, data, valid and kill. A parallel kill port marks
// every live entry whose rd matches kill_rd; two query ports report whether
// any live, unkilled entry targets a given register.
//   clock, ctrl_reset         : clock, synchronous active-low reset
//   push, push_req, push_kill : enqueue at tail (caller guarantees not full)
//   pop                       : dequeue head (caller guarantees not empty)
//   head_req, head_kill       : current head entry
//   kill_en, kill_rd          : kill all live entries with rd == kill_rd
//   query_a/b, match_a/b      : rd-match lookups over live unkilled entries
//   count                     : occupancy, killed entries included
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     push,
  input  wb_req_t                  push_req,
  input  logic                     push_kill,
  input  logic                     pop,
  output wb_req_t                  head_req,
  output logic                     head_kill,
  input  logic                     kill_en,
  input  logic [REG_W-1:0]         kill_rd,
  input  logic [REG_W-1:0]         query_a,
  input  logic [REG_W-1:0]         query_b,
  output logic                     match_a,
  output logic                     match_b,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;

  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  kill_q;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  always_ff @(posedge clock) begin
    if (push) begin
      rd_q[tail]   <= push_req.rd;
      data_q[tail] <= push_req.data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; full/empty come
  // from count alone. kill_en and pop are never both set by the arbiter, and
  // the tail slot is never valid when pushed, so the updates below don't clash.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
      kill_q  <= '0;
    end else begin
      if (kill_en) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && (rd_q[i] == kill_rd)) kill_q[i] <= 1'b1;
        end
      end
      if (pop) begin
        valid_q[head] <= 1'b0;
        kill_q[head]  <= 1'b0;
        head          <= head + PTR_ONE;
      end
      if (push) begin
        valid_q[tail] <= 1'b1;
        kill_q[tail]  <= push_kill;
        tail          <= tail + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head_req.rd   = rd_q[head];
  assign head_req.data = data_q[head];
  assign head_kill     = kill_q[head];

  always_comb begin
    match_a = 1'b0;
    match_b = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !kill_q[i] && (rd_q[i] == query_a)) match_a = 1'b1;
      if (valid_q[i] && !kill_q[i] && (rd_q[i] == query_b)) match_b = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side initiator for the 32x32 register file. Merges single-cycle
// pipeline writebacks with queued multdiv results onto one registered write
// port; the pipeline always wins and the queue drains only in idle cycles.
//   clock, ctrl_reset        : clock, synchronous active-low reset
//   pipe_we/pipe_rd/pipe_data: pipeline writeback
//   md (slave)               : multdiv result handshake
//   query_a/b, hazard_a/b    : decode operand hazard lookup
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg : register file write port
//   q_count                  : queue occupancy, killed entries included
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned REG_W  = regfile_wb_arbiter_pkg::REG_W,
  parameter int unsigned DATA_W = regfile_wb_arbiter_pkg::DATA_W
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  input  logic                   pipe_we,
  input  logic [REG_W-1:0]       pipe_rd,
  input  logic [DATA_W-1:0]      pipe_data,
  regfile_wb_arbiter_if.slave    md,
  input  logic [REG_W-1:0]       query_a,
  input  logic [REG_W-1:0]       query_b,
  output logic                   hazard_a,
  output logic                   hazard_b,
  output logic                   ctrl_writeEnable,
  output logic [REG_W-1:0]       ctrl_writeReg,
  output logic [DATA_W-1:0]      data_writeReg,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  wb_req_t push_req;
  wb_req_t head_req;
  logic    head_kill;
  logic    push_kill;
  logic    accept;
  logic    pop;
  logic    pipe_sel;
  logic    match_a;
  logic    match_b;

  assign md.md_ready = (q_count < FULL);
  assign accept      = md.md_valid && md.md_ready;

  // Any pipe_we (even to r0) blocks the drain; only nonzero rd issues.
  assign pipe_sel = pipe_we && (pipe_rd != '0);
  assign pop      = !pipe_we && (q_count != '0);

  // The pipeline write is younger than any multdiv result, so a same-cycle
  // result to the same register must never land; r0 results never land.
  assign push_req.rd   = md.md_rd;
  assign push_req.data = md.md_data;
  assign push_kill     = (md.md_rd == '0) || (pipe_we && (pipe_rd == md.md_rd));

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .push       (accept),
    .push_req   (push_req),
    .push_kill  (push_kill),
    .pop        (pop),
    .head_req   (head_req),
    .head_kill  (head_kill),
    .kill_en    (pipe_we),
    .kill_rd    (pipe_rd),
    .query_a    (query_a),
    .query_b    (query_b),
    .match_a    (match_a),
    .match_b    (match_b),
    .count      (q_count)
  );

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else if (pipe_sel) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= pipe_rd;
      data_writeReg    <= pipe_data;
    end else if (pop) begin
      ctrl_writeEnable <= !head_kill && (head_req.rd != '0);
      ctrl_writeReg    <= head_req.rd;
      data_writeReg    <= head_req.data;
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

  always_comb begin
    hazard_a = (query_a != '0) &&
               (match_a ||
                (ctrl_writeEnable && (ctrl_writeReg == query_a)) ||
                (md.md_valid && (md.md_rd == query_a)));
    hazard_b = (query_b != '0) &&
               (match_b ||
                (ctrl_writeEnable && (ctrl_writeReg == query_b)) ||
                (md.md_valid && (md.md_rd == query_b)));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        ctrl_reset;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic [4:0]  query_a;
  logic [4:0]  query_b;
  logic        hazard_a;
  logic        hazard_b;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [2:0]  q_count;

  regfile_wb_arbiter_if md_if ();

  regfile_wb_arbiter #(.DEPTH(4), .REG_W(5), .DATA_W(32)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .pipe_we          (pipe_we),
    .pipe_rd          (pipe_rd),
    .pipe_data        (pipe_data),
    .md               (md_if.slave),
    .query_a          (query_a),
    .query_b          (query_b),
    .hazard_a         (hazard_a),
    .hazard_b         (hazard_b),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .q_count          (q_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          kill;
  } ent_t;

  typedef struct {
    bit          en;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  logic [31:0] rf [32];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model advances on the inputs presented before the edge and
  // queues the expected output-stage contents; checked #1 after the edge.
  task automatic step();
    exp_t e;
    exp_t got;
    ent_t h;
    bit   acc;
    e   = '{en: 1'b0, rd: 5'd0, data: 32'd0};
    acc = 1'b0;
    if (!ctrl_reset) begin
      mq.delete();
    end else begin
      acc = md_if.md_valid && (mq.size() < 4);
      if (pipe_we) begin
        foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].kill = 1'b1;
      end
      if (pipe_we && pipe_rd != 5'd0) begin
        e = '{en: 1'b1, rd: pipe_rd, data: pipe_data};
      end else if (!pipe_we && mq.size() > 0) begin
        h = mq.pop_front();
        if (!h.kill && h.rd != 5'd0) e = '{en: 1'b1, rd: h.rd, data: h.data};
      end
      if (acc) begin
        mq.push_back('{rd: md_if.md_rd, data: md_if.md_data,
                       kill: (md_if.md_rd == 5'd0) || (pipe_we && pipe_rd == md_if.md_rd)});
      end
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (acc) md_if.md_valid = 1'b0;
    got = sb.pop_front();
    check("wen", {63'd0, ctrl_writeEnable}, {63'd0, got.en});
    if (got.en) begin
      check("wreg", {59'd0, ctrl_writeReg}, {59'd0, got.rd});
      check("wdata", {32'd0, data_writeReg}, {32'd0, got.data});
    end
    if (ctrl_writeEnable) rf[ctrl_writeReg] = data_writeReg;
    check("q_count", {61'd0, q_count}, 64'(mq.size()));
    check("md_ready", {63'd0, md_if.md_ready}, {63'd0, mq.size() < 4});
  endtask

  task automatic hz(input logic [4:0] qa, input logic [4:0] qb, input bit ea, input bit eb);
    query_a = qa;
    query_b = qb;
    #1;
    check("hazard_a", {63'd0, hazard_a}, {63'd0, ea});
    check("hazard_b", {63'd0, hazard_b}, {63'd0, eb});
  endtask

  task automatic md_put(input logic [4:0] rd, input logic [31:0] data);
    md_if.md_valid = 1'b1;
    md_if.md_rd    = rd;
    md_if.md_data  = data;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    ctrl_reset = 1'b0;
    pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    query_a = '0; query_b = '0;
    md_if.md_valid = 1'b0; md_if.md_rd = '0; md_if.md_data = '0;

    // reset and idle
    step(); step();
    ctrl_reset = 1'b1;
    step();
    check("rst_wreg", {59'd0, ctrl_writeReg}, 64'd0);
    check("rst_wdata", {32'd0, data_writeReg}, 64'd0);
    hz(5'd5, 5'd7, 1'b0, 1'b0);

    // pipeline write with concurrent multdiv result
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h12345678;
    md_put(5'd7, 32'h0000_7777);
    step();
    check("t1_reg", {59'd0, ctrl_writeReg}, 64'd5);
    check("t1_data", {32'd0, data_writeReg}, 64'h12345678);
    hz(5'd5, 5'd7, 1'b1, 1'b1);
    pipe_we = 1'b0;
    step();
    check("t1_md_reg", {59'd0, ctrl_writeReg}, 64'd7);
    step();

    // fill the queue behind a continuous pipeline stream
    pipe_we = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h99;
    for (int i = 0; i < 4; i++) begin
      md_put(5'(10 + i), 32'h1000 + 32'(i));
      step();
    end
    check("full_cnt", {61'd0, q_count}, 64'd4);
    check("full_rdy", {63'd0, md_if.md_ready}, 64'd0);
    for (int i = 0; i < 4; i++) hz(5'(10 + i), 5'd0, 1'b1, 1'b0);
    pipe_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_rd", {59'd0, ctrl_writeReg}, 64'(10 + i));
      check("drain_en", {63'd0, ctrl_writeEnable}, 64'd1);
    end
    step();

    // stale queued write overtaken by a pipeline write
    md_put(5'd3, 32'hAAAA);
    step();
    hz(5'd3, 5'd0, 1'b1, 1'b0);
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hBBBB;
    step();
    pipe_we = 1'b0;
    step();
    check("stale_en", {63'd0, ctrl_writeEnable}, 64'd0);
    step();
    check("r3", {32'd0, rf[3]}, 64'hBBBB);

    // same-cycle pipeline and multdiv to the same register
    pipe_we = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h4444;
    md_put(5'd4, 32'h4040);
    hz(5'd4, 5'd0, 1'b1, 1'b0);
    step();
    pipe_we = 1'b0;
    step();
    step();
    check("r4", {32'd0, rf[4]}, 64'h4444);

    // multdiv result to r0
    md_put(5'd0, 32'hFFFF);
    hz(5'd0, 5'd0, 1'b0, 1'b0);
    step();
    check("r0_cnt", {61'd0, q_count}, 64'd1);
    step();
    check("r0_en", {63'd0, ctrl_writeEnable}, 64'd0);
    step();
    check("r0", {32'd0, rf[0]}, 64'd0);

    // pipe_we to r0 blocks drain, then reset with entries queued
    pipe_we = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h9999;
    for (int i = 0; i < 3; i++) begin
      md_put(5'(20 + i), 32'h2000 + 32'(i));
      step();
    end
    pipe_rd = 5'd0;
    step();
    check("r0pipe_cnt", {61'd0, q_count}, 64'd3);
    pipe_we = 1'b0;
    ctrl_reset = 1'b0;
    step();
    check("mid_rst_cnt", {61'd0, q_count}, 64'd0);
    ctrl_reset = 1'b1;
    for (int i = 0; i < 4; i++) step();
    hz(5'd20, 5'd21, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
